// File: rtl/ogege_pkg.sv
// rtl/ogege_pkg.sv - shared op codes, FSM encoding and default alpha width
package ogege_pkg;

    localparam int ALPHA_W_DEF = 3;

    localparam logic [1:0] OP_SET      = 2'd0;
    localparam logic [1:0] OP_FADE_IN  = 2'd1;
    localparam logic [1:0] OP_FADE_OUT = 2'd2;
    localparam logic [1:0] OP_FADE_TO  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FADE = 2'd2
    } state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle tick on the inactive->active vsync edge
module frame_tick_gen #(
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_vsync,
    output logic o_tick
);

    localparam logic ACT_LVL = ~VSYNC_ACTIVE_LOW;

    logic vs_q;
    logic vs_d;

    always_comb begin
        vs_d = i_vsync;
    end

    // History starts at the active level so leaving reset mid-pulse is not an edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vs_q <= ACT_LVL;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign o_tick = (i_vsync == ACT_LVL) && (vs_q != ACT_LVL);

endmodule

// File: rtl/blend_fade_ctrl.sv
// rtl/blend_fade_ctrl.sv - frame-aligned SET/FADE sequencer for the blender alpha
module blend_fade_ctrl
    import ogege_pkg::*;
#(
    parameter int ALPHA_W          = ALPHA_W_DEF,
    parameter int RATE_W           = 4,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int ALPHA_RESET      = 0
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               i_vsync,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [ALPHA_W-1:0] i_cmd_alpha,
    input  logic [RATE_W-1:0]  i_cmd_rate,
    input  logic               i_abort,
    output logic [ALPHA_W-1:0] o_alpha,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [ALPHA_W-1:0] AMAX  = '1;
    localparam logic [ALPHA_W-1:0] A_RST = ALPHA_W'(ALPHA_RESET);
    localparam logic [RATE_W-1:0]  R_ONE = RATE_W'(1);

    state_e             state_q, state_d;
    logic [ALPHA_W-1:0] alpha_q, alpha_d;
    logic [ALPHA_W-1:0] target_q, target_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic [RATE_W-1:0]  cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               tick;
    logic               accept;
    logic [RATE_W-1:0]  cnt_inc;
    logic [ALPHA_W-1:0] alpha_step;

    frame_tick_gen #(
        .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW)
    ) u_tick (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .i_vsync(i_vsync),
        .o_tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        alpha_d    = alpha_q;
        target_d   = target_q;
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        accept     = i_cmd_valid && (state_q == IDLE) && !i_abort;
        cnt_inc    = cnt_q + R_ONE;
        alpha_step = (alpha_q < target_q) ? alpha_q + ALPHA_W'(1) : alpha_q - ALPHA_W'(1);

        // Completion leaves the FSM busy for the o_done cycle, so ready rises one cycle later.
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (i_cmd_op)
                        OP_FADE_IN:  target_d = AMAX;
                        OP_FADE_OUT: target_d = '0;
                        default:     target_d = i_cmd_alpha;
                    endcase
                    rate_d  = (i_cmd_rate == '0) ? R_ONE : i_cmd_rate;
                    cnt_d   = '0;
                    state_d = (i_cmd_op == OP_SET) ? PEND : FADE;
                end
            end
            PEND: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    alpha_d = target_q;
                    done_d  = 1'b1;
                end
            end
            FADE: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (alpha_q == target_q) begin
                        done_d = 1'b1;
                    end else if (cnt_inc == rate_q) begin
                        cnt_d   = '0;
                        alpha_d = alpha_step;
                        done_d  = (alpha_step == target_q);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            alpha_d = alpha_q;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            alpha_q  <= A_RST;
            target_q <= A_RST;
            rate_q   <= R_ONE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            alpha_q  <= alpha_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign o_alpha     = alpha_q;
    assign o_busy      = (state_q != IDLE);
    assign o_cmd_ready = (state_q == IDLE);
    assign o_done      = done_q;

endmodule

// File: tb/tb_blend_fade_ctrl.sv
// tb/tb_blend_fade_ctrl.sv - randomized and directed bench against a closed-form fade model
module tb_blend_fade_ctrl;
    import ogege_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       vsync_a = 1'b0;
    logic       vsync_b = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_alpha = 3'd0;
    logic [3:0] cmd_rate = 4'd0;
    logic       abort = 1'b0;

    logic       rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
    logic [2:0] alpha_a, alpha_b;

    always #5 clk = ~clk;

    blend_fade_ctrl #(.ALPHA_W(3), .RATE_W(4), .VSYNC_ACTIVE_LOW(1'b1), .ALPHA_RESET(0)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .i_vsync(vsync_a), .i_cmd_valid(cmd_valid),
        .o_cmd_ready(rdy_a), .i_cmd_op(cmd_op), .i_cmd_alpha(cmd_alpha),
        .i_cmd_rate(cmd_rate), .i_abort(abort), .o_alpha(alpha_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    blend_fade_ctrl #(.ALPHA_W(3), .RATE_W(4), .VSYNC_ACTIVE_LOW(1'b0), .ALPHA_RESET(0)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .i_vsync(vsync_b), .i_cmd_valid(cmd_valid),
        .o_cmd_ready(rdy_b), .i_cmd_op(cmd_op), .i_cmd_alpha(cmd_alpha),
        .i_cmd_rate(cmd_rate), .i_abort(abort), .o_alpha(alpha_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // model: phase 0 idle, 1 working, 2 done-pulse cycle
    int m_phase, m_alpha, m_start, m_tgt, m_R, m_k;
    bit m_set, m_done, m_prev_act;
    int vcnt, fper;
    bit v_act;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("alpha_a", 32'(alpha_a), 32'(m_alpha));
        chk("done_a", 32'(done_a), 32'(m_done));
        chk("busy_a", 32'(busy_a), 32'(m_phase != 0));
        chk("ready_a", 32'(rdy_a), 32'(m_phase == 0));
        chk("alpha_b", 32'(alpha_b), 32'(m_alpha));
        chk("done_b", 32'(done_b), 32'(m_done));
        chk("busy_b", 32'(busy_b), 32'(m_phase != 0));
    endtask

    task automatic cycle();
        bit tick;
        int diff, steps;
        vsync_a = !v_act;
        vsync_b = v_act;
        tick = v_act && !m_prev_act;
        @(posedge clk);
        m_prev_act = v_act;
        if (m_phase == 2) begin
            m_phase = 0;
            m_done  = 0;
        end else if (abort && m_phase == 1) begin
            m_phase = 0;
            m_done  = 0;
        end else if (m_phase == 0) begin
            m_done = 0;
            if (cmd_valid && !abort) begin
                m_set   = (cmd_op == OP_SET);
                m_tgt   = (cmd_op == OP_FADE_IN) ? 7 : (cmd_op == OP_FADE_OUT) ? 0 : int'(cmd_alpha);
                m_R     = (cmd_rate == 0) ? 1 : int'(cmd_rate);
                m_start = m_alpha;
                m_k     = 0;
                m_phase = 1;
            end
        end else if (tick) begin
            if (m_set) begin
                m_alpha = m_tgt;
                m_done  = 1;
                m_phase = 2;
            end else begin
                m_k++;
                diff  = (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
                steps = (m_k / m_R < diff) ? m_k / m_R : diff;
                m_alpha = (m_tgt > m_start) ? m_start + steps : m_start - steps;
                if ((diff == 0) ? (m_k == 1) : (m_k == diff * m_R)) begin
                    m_done  = 1;
                    m_phase = 2;
                end
            end
        end
        #1;
        check_all();
        vcnt++;
        if (vcnt >= fper) begin
            vcnt = 0;
            fper = $urandom_range(6, 14);
        end
        v_act = (vcnt < 2);
    endtask

    task automatic do_reset();
        v_act   = 1;
        vcnt    = 0;
        fper    = 10;
        vsync_a = 1'b0;
        vsync_b = 1'b1;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_alpha", 32'(alpha_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        m_phase = 0; m_alpha = 0; m_done = 0; m_prev_act = 1;
        m_start = 0; m_tgt = 0; m_R = 1; m_k = 0; m_set = 0;
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic send(input logic [1:0] op, input int a, input int r);
        bit took = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_alpha = a[2:0];
        cmd_rate  = r[3:0];
        for (int i = 0; i < 400 && !took; i++) begin
            took = (m_phase == 0) && !abort;
            cycle();
        end
        cmd_valid = 1'b0;
        if (!took) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            cycle();
            seen = m_done;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        cycle();
    endtask

    task automatic run_until_alpha(input int a);
        bit hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cycle();
            hit = (m_alpha == a);
        end
        if (!hit) chk("alpha_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        do_reset();
        cycle();
        cycle();
        chk("no_tick_after_rst", 32'(alpha_a), 32'd0);

        send(OP_SET, 5, 1);
        chk("set_not_early", 32'(alpha_a), 32'd0);
        wait_done();
        chk("set_alpha", 32'(alpha_a), 32'd5);
        send(OP_FADE_OUT, 0, 0);
        wait_done();
        chk("fade_out_rate0", 32'(alpha_a), 32'd0);
        send(OP_FADE_IN, 0, 2);
        wait_done();
        chk("fade_in_r2", 32'(alpha_a), 32'd7);
        send(OP_FADE_TO, 7, 3);
        wait_done();
        chk("fade_to_same", 32'(alpha_a), 32'd7);
        send(OP_FADE_TO, 6, 1);
        send(OP_FADE_TO, 2, 1);
        wait_done();
        chk("fade_to_down", 32'(alpha_a), 32'd2);
        send(OP_FADE_OUT, 0, 1);
        wait_done();
        send(OP_FADE_OUT, 0, 1);
        wait_done();
        chk("fade_out_from0", 32'(alpha_a), 32'd0);

        send(OP_FADE_IN, 0, 1);
        wait_done();
        send(OP_FADE_OUT, 0, 3);
        run_until_alpha(3);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_hold", 32'(alpha_a), 32'd3);
        chk("abort_idle", 32'(busy_a), 32'd0);
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_alpha = 3'd6; abort = 1'b1;
        cycle();
        cmd_valid = 1'b0; abort = 1'b0;
        chk("abort_drop_busy", 32'(busy_a), 32'd0);
        repeat (30) cycle();
        chk("abort_drop_alpha", 32'(alpha_a), 32'd3);

        send(OP_FADE_IN, 0, 1);
        run_until_alpha(4);
        do_reset();
        cycle();
        cycle();
        chk("rst_mid_fade", 32'(alpha_a), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_alpha = 3'($urandom_range(0, 7));
            cmd_rate  = 4'($urandom_range(0, 3));
            abort     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
